// File: rtl/spi_rm3100_pkg.sv
// Shared types and constants for the RM3100 SPI responder.
package spi_rm3100_pkg;

  typedef enum logic [2:0] {
    WAIT_CS,
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA
  } state_t;

  localparam int unsigned RW_BIT    = 7;
  localparam int unsigned BYTE_BITS = 8;

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizers for sclk, cs_n and mosi, with single-clk edge pulses for sclk and cs_n.
module spi_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic cs_n_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;

  // cs_n chain resets to "selected" so a frame already in progress at reset
  // release is never mistaken for a fresh one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sr <= '1;
      cs_sr   <= '0;
      mosi_sr <= '0;
      sclk_d  <= 1'b1;
      cs_d    <= 1'b0;
    end else begin
      sclk_sr[0] <= sclk;
      cs_sr[0]   <= cs_n;
      mosi_sr[0] <= mosi;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sr[i] <= sclk_sr[i-1];
        cs_sr[i]   <= cs_sr[i-1];
        mosi_sr[i] <= mosi_sr[i-1];
      end
      sclk_d <= sclk_sr[SYNC_STAGES-1];
      cs_d   <= cs_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign cs_n_s    = cs_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_n_s & ~cs_d;
  assign cs_fall   = ~cs_n_s & cs_d;

endmodule

// File: rtl/spi_rm3100_slave.sv
// SPI mode-3 responder for the RM3100 register protocol with an external register port.
// Define RM3100_AUTOINC_EN for multi-byte bursts with address auto-increment.
module spi_rm3100_slave
  import spi_rm3100_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              frame_done
);

`ifdef RM3100_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_n_s, mosi_s;

  spi_slave_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .cs_n_s    (cs_n_s),
    .mosi_s    (mosi_s)
  );

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [BYTE_BITS-2:0]   rx_shift;
  logic [BYTE_BITS-1:0]   tx_shift;
  logic [BYTE_BITS-1:0]   byte_val;
  logic [ADDR_W-1:0]      addr;
  logic                   byte_done;
  logic                   active;
  logic                   commit_wr;
  logic                   byte_seen;
  logic                   data_taken;
  logic                   rd_pend;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (cs_fall) begin
      bit_cnt  <= '0;
    end else if (sclk_rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= {rx_shift[BYTE_BITS-3:0], mosi_s};
    end
  end

  assign byte_val  = {rx_shift, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'(BYTE_BITS - 1));
  assign active    = (state == CMD) || (state == WR_DATA) || (state == RD_DATA);
  assign commit_wr = (state == WR_DATA) && byte_done && (AUTOINC || !data_taken);

  // Write commit sits outside the cs_rise branch so a byte finishing in the
  // same clk as deselect is still written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= WAIT_CS;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      frame_done <= 1'b0;
      tx_shift   <= '0;
      addr       <= '0;
      byte_seen  <= 1'b0;
      data_taken <= 1'b0;
      rd_pend    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      rd_req     <= 1'b0;
      frame_done <= 1'b0;
      rd_pend    <= rd_req;

      if (byte_done && active) byte_seen <= 1'b1;

      if (commit_wr) begin
        wr_en      <= 1'b1;
        wr_addr    <= addr;
        wr_data    <= byte_val;
        data_taken <= 1'b1;
        if (AUTOINC) addr <= addr + ADDR_W'(1);
      end

      if (cs_rise) begin
        state      <= IDLE;
        miso       <= 1'b0;
        miso_oe    <= 1'b0;
        frame_done <= byte_seen | (byte_done & active);
        byte_seen  <= 1'b0;
      end else begin
        case (state)
          WAIT_CS: if (cs_n_s) state <= IDLE;
          IDLE: begin
            if (cs_fall) begin
              state      <= CMD;
              miso_oe    <= 1'b1;
              data_taken <= 1'b0;
            end
          end
          CMD: begin
            if (byte_done) begin
              addr <= ADDR_W'(byte_val[6:0]);
              if (byte_val[RW_BIT]) begin
                rd_req  <= 1'b1;
                rd_addr <= ADDR_W'(byte_val[6:0]);
                state   <= RD_DATA;
              end else begin
                state   <= WR_DATA;
              end
            end
          end
          WR_DATA: ;
          RD_DATA: begin
            if (sclk_fall) begin
              miso     <= tx_shift[BYTE_BITS-1];
              tx_shift <= {tx_shift[BYTE_BITS-2:0], 1'b0};
            end
            // Without auto-increment the shifter simply drains to zero.
            if (byte_done && AUTOINC) begin
              addr    <= addr + ADDR_W'(1);
              rd_addr <= addr + ADDR_W'(1);
              rd_req  <= 1'b1;
            end
            if (rd_pend) tx_shift <= rd_data;
          end
          default: state <= WAIT_CS;
        endcase
      end
    end
  end

endmodule
